// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package riscv_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch bundle: redirect input, instruction-memory port and IF/ID handshake.
interface imem_fetch_ctrl_if;
  import riscv_fetch_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, if_ready,
    output imem_en, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, if_ready,
    input  imem_en, imem_addr, if_valid, if_pc, if_instr
  );

endinterface

// File: rtl/imem_fetch_ctrl_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with clear; storage is not reset.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push = push & (count != (AW+1)'(DEPTH));
    do_pop  = pop & (count != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle synchronous instruction memory.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module imem_fetch_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  imem_fetch_ctrl_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_p1;
  logic            vld_p1;
  logic [CNT_W-1:0] count;
  logic [2*XLEN-1:0] head;
  logic [CNT_W:0]  occ;
  logic            credit_ok;
  logic            issue;
  logic            pop;
  logic            push;
  logic            clear;

  // Credit covers both buffered entries and the read still in flight.
  always_comb begin
    occ       = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1} - {{CNT_W{1'b0}}, pop};
    credit_ok = occ < (CNT_W+1)'(DEPTH);
  end

  assign bus.if_valid  = (count != '0) & !bus.redirect_valid;
  assign pop           = bus.if_valid & bus.if_ready;
  assign issue         = (state != BOOT) & !bus.redirect_valid & credit_ok;
  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc;
  assign push          = vld_p1 & (state != FLUSH);
  assign clear         = bus.redirect_valid & (state != BOOT);
  assign bus.if_pc     = (count != '0) ? head[2*XLEN-1:XLEN] : '0;
  assign bus.if_instr  = (count != '0) ? head[XLEN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (bus.redirect_valid) pc <= align_word(bus.redirect_pc);
      else if (issue)         pc <= pc + 32'd4;
      case (state)
        BOOT:    state <= RUN;
        default: state <= bus.redirect_valid ? FLUSH : RUN;
      endcase
    end
  end

  // Stage p0 -> p1: remember the PC of the read whose data returns next cycle.
  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= pc;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (2*XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   ({pc_p1, bus.imem_rdata}),
    .dout  (head),
    .count (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (bus.if_valid && !bus.if_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a 1-cycle memory holding mem[i]=i.
module tb_imem_fetch_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [31:0] mem [1024];

  imem_fetch_ctrl_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  imem_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr[11:2]];
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
    chk({tag, "_valid"}, {31'd0, bus.if_valid}, {31'd0, v});
    if (v) begin
      chk({tag, "_pc"}, bus.if_pc, p);
      chk({tag, "_instr"}, bus.if_instr, i);
    end
  endtask

  task automatic chk_issue(input string tag, input logic en, input logic [31:0] a);
    chk({tag, "_en"}, {31'd0, bus.imem_en}, {31'd0, en});
    if (en) chk({tag, "_addr"}, bus.imem_addr, a);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 1024; i++) mem[i] = i;
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.if_ready = 1'b0;
    next();
    next();

    #1;
    chk("rst_en", {31'd0, bus.imem_en}, 32'd0);
    chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_pc", bus.if_pc, 32'h0);
    chk("rst_instr", bus.if_instr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_stall", perf_stall, 32'd0);
`endif

    // BOOT cycle, then streaming with if_ready=1
    rst = 1'b1;
    bus.if_ready = 1'b1;
    #1;
    chk_issue("boot", 1'b0, 32'h0);
    next(); #1; chk_issue("c1", 1'b1, 32'h0); chk_out("c1", 1'b0, 0, 0);
    next(); #1; chk_issue("c2", 1'b1, 32'h4); chk_out("c2", 1'b0, 0, 0);
    next(); #1; chk_issue("c3", 1'b1, 32'h8); chk_out("c3", 1'b1, 32'h0, 32'd0);
    next(); #1; chk_out("c4", 1'b1, 32'h4, 32'd1);
    next(); #1; chk_out("c5", 1'b1, 32'h8, 32'd2);

    // Stall 5 cycles: credit exhausted, head held
    next(); bus.if_ready = 1'b0; #1;
    chk_out("stall0", 1'b1, 32'hc, 32'd3);
    chk_issue("stall0", 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      next(); #1;
      chk_out("stall", 1'b1, 32'hc, 32'd3);
      chk_issue("stall", 1'b0, 0);
    end
    next(); bus.if_ready = 1'b1; #1;
    chk_out("resume0", 1'b1, 32'hc, 32'd3);
    chk_issue("resume0", 1'b1, 32'h14);
    next(); #1; chk_out("resume1", 1'b1, 32'h10, 32'd4);

    // Fill the FIFO, then redirect to 0x100
    next(); bus.if_ready = 1'b0; #1; chk_out("pre_rd", 1'b1, 32'h14, 32'd5);
    next(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; #1;
    chk_out("rd_cyc", 1'b0, 0, 0);
    chk_issue("rd_cyc", 1'b0, 0);
    next(); bus.redirect_valid = 1'b0; bus.if_ready = 1'b1; #1;
    chk_out("flush", 1'b0, 0, 0);
    chk_issue("flush", 1'b1, 32'h100);
    next(); #1; chk_out("rd_p2", 1'b0, 0, 0); chk_issue("rd_p2", 1'b1, 32'h104);
    next(); #1; chk_out("rd_first", 1'b1, 32'h100, 32'h40);
    next(); #1; chk_out("rd_second", 1'b1, 32'h104, 32'h41);

    // Misaligned redirect while a read is in flight
    next(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203; #1;
    chk_out("mis_cyc", 1'b0, 0, 0);
    next(); bus.redirect_valid = 1'b0; #1; chk_issue("mis_flush", 1'b1, 32'h200);
    next(); #1; chk_out("mis_p2", 1'b0, 0, 0);
    next(); #1; chk_out("mis_first", 1'b1, 32'h200, 32'h80);

    // Back-to-back redirects: only the 0x80 stream survives
    next(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; #1;
    chk_out("bb0", 1'b0, 0, 0);
    next(); bus.redirect_pc = 32'h80; #1;
    chk_out("bb1", 1'b0, 0, 0);
    chk_issue("bb1", 1'b0, 0);
    next(); bus.redirect_valid = 1'b0; #1;
    chk_issue("bb_flush", 1'b1, 32'h80);
    chk_out("bb_flush", 1'b0, 0, 0);
    next(); #1; chk_out("bb_p2", 1'b0, 0, 0);
    next(); #1; chk_out("bb_first", 1'b1, 32'h80, 32'h20);
    next(); #1; chk_out("bb_second", 1'b1, 32'h84, 32'h21);

    // Synchronous reset mid-stream with data pending
    next(); rst = 1'b0;
    next(); rst = 1'b1; #1;
    chk_out("mrst", 1'b0, 0, 0);
    chk_issue("mrst", 1'b0, 0);
    chk("mrst_addr", bus.imem_addr, 32'h0);
    chk("mrst_pc", bus.if_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("mrst_perf_fetched", perf_fetched, 32'd0);
    chk("mrst_perf_stall", perf_stall, 32'd0);
`endif
    next(); #1; chk_issue("mrst1", 1'b1, 32'h0);
    next(); #1; chk_out("mrst2", 1'b0, 0, 0);
    next(); #1; chk_out("mrst3", 1'b1, 32'h0, 32'd0);

    // Ten pops in a row, then three stall cycles
    for (int k = 1; k < 10; k++) begin
      next(); #1;
      chk_out("run10", 1'b1, 32'(4 * k), 32'(k));
    end
    next(); bus.if_ready = 1'b0;
    next();
    next();
    next(); #1;
    chk_out("hold_end", 1'b1, 32'h28, 32'd10);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_stall", perf_stall, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
